// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the MMIO controller: I/O address map, FSM state
// encoding, read-source encoding and a byte-lane helper.
package mmio_ctrl_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STOP   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_RX   = 2'd1,
        SEL_CNT  = 2'd2,
        SEL_ZERO = 2'd3
    } rd_sel_e;

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy counter; push-on-full and pop-on-empty
// are ignored, simultaneous push and pop keep the occupancy unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// CPU bus decoder: RAM pass-through, UART TX/RX FIFOs, cycle counter with
// byte-wise snapshot reads, and a RUN/STOP/HALTED shutdown sequence.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [17:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    output logic        ram_we,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted
);
    state_e      state_r;
    state_e      state_nxt_s;
    rd_sel_e     sel_r;
    logic        rd_pend_r;
    logic [7:0]  byte_r;
    logic [31:0] cnt_r;
    logic [31:0] snap_r;

    logic        io_s, rd_s, wr_s, uart_hit_s, cnt_hit_s, cnt_blk_s;
    logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]  tx_wdata_s, rx_head_s;

    assign io_s       = (mem_a[17:16] == 2'b11);
    assign rdy_out    = (state_r == ST_RUN) & ~tx_full_s;
    assign rd_s       = rdy_out & ~mem_wr;
    assign wr_s       = rdy_out & mem_wr;
    assign uart_hit_s = (mem_a == IO_UART_ADDR);
    assign cnt_hit_s  = (mem_a == IO_CNT_ADDR);
    assign cnt_blk_s  = (mem_a[17:2] == IO_CNT_ADDR[17:2]);

    assign ram_we    = mem_wr & ~io_s & rdy_out;
    assign ram_addr  = mem_a[16:0];
    assign ram_wdata = mem_dout;

    // The stop write enqueues a terminating 0x00 that the normal filter would drop.
    assign tx_push_s  = wr_s & ((uart_hit_s & (mem_dout != 8'h00)) | cnt_hit_s);
    assign tx_wdata_s = cnt_hit_s ? 8'h00 : mem_dout;
    assign tx_valid   = ~tx_empty_s;
    assign tx_pop_s   = ~tx_empty_s & tx_ready;

    assign rx_ready   = ~rx_full_s;
    assign rx_push_s  = rx_valid & ~rx_full_s;
    assign rx_pop_s   = rd_s & uart_hit_s & ~rx_empty_s;

    assign halted     = (state_r == ST_HALTED);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push_s),
        .wdata (tx_wdata_s),
        .pop   (tx_pop_s),
        .rdata (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_push_s),
        .wdata (rx_data),
        .pop   (rx_pop_s),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_r <= ST_RUN;
        else         state_r <= state_nxt_s;
    end

    // FSM next state; HALTED is left only through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (wr_s & cnt_hit_s) state_nxt_s = ST_STOP;
                else                  state_nxt_s = ST_RUN;
            end
            ST_STOP: begin
                if (tx_empty_s) state_nxt_s = ST_HALTED;
                else            state_nxt_s = ST_STOP;
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Free-running cycle counter, frozen once halted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                  cnt_r <= 32'd0;
        else if (state_r != ST_HALTED) cnt_r <= cnt_r + 32'd1;
        else                          cnt_r <= cnt_r;
    end

    // Read-source select and captured I/O byte for the following cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_r     <= SEL_RAM;
            rd_pend_r <= 1'b0;
            byte_r    <= 8'h00;
            snap_r    <= 32'd0;
        end else begin
            rd_pend_r <= rd_s;
            if (rd_s) begin
                if (!io_s) begin
                    sel_r <= SEL_RAM;
                end else if (uart_hit_s) begin
                    sel_r  <= SEL_RX;
                    byte_r <= rx_empty_s ? 8'h00 : rx_head_s;
                end else if (cnt_blk_s) begin
                    sel_r <= SEL_CNT;
                    if (mem_a[1:0] == 2'b00) begin
                        snap_r <= cnt_r;
                        byte_r <= cnt_r[7:0];
                    end else begin
                        byte_r <= byte_of(snap_r, mem_a[1:0]);
                    end
                end else begin
                    sel_r  <= SEL_ZERO;
                    byte_r <= 8'h00;
                end
            end
        end
    end

    // Read data mux; RAM data arrives one cycle after its address.
    always_comb begin
        mem_din = 8'h00;
        if (rd_pend_r) begin
            case (sel_r)
                SEL_RAM: mem_din = ram_rdata;
                SEL_RX:  mem_din = byte_r;
                SEL_CNT: mem_din = byte_r;
                default: mem_din = 8'h00;
            endcase
        end else begin
            mem_din = 8'h00;
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl with read and TX scoreboards.
module tb_mmio_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [17:0] mem_a = 18'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halted;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc;
    logic [31:0] rd_exp [$];
    logic [31:0] tx_exp [$];
    logic [7:0]  tx_obs [$];
    bit   [7:0]  ram_mem [0:131071];

    mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .rdy_out   (rdy_out),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halted    (halted)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM, one-cycle read latency.
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Edges since reset release.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Record every byte the UART side accepts.
    always @(negedge clk_in) begin
        if (rst_in && tx_valid && tx_ready) tx_obs.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_din"},  {24'h0, mem_din}, 32'h00);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h1);
        check({tag, "_rdy_out"},  {31'h0, rdy_out},  32'h1);
        check({tag, "_halted"},   {31'h0, halted},   32'h0);
    endtask

    // Present one bus access, hold it until accepted, then return to idle.
    task automatic bus(input logic [17:0] addr, input logic wr, input logic [7:0] data);
        int k = 0;
        mem_a = addr; mem_wr = wr; mem_dout = data;
        @(negedge clk_in);
        while (!rdy_out && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        check("bus_accept", {31'h0, rdy_out}, 32'h1);
        @(posedge clk_in); #1;
        mem_a = 18'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    endtask

    task automatic cpu_read(input string tag, input logic [17:0] addr, input logic [7:0] exp);
        rd_exp.push_back({24'h0, exp});
        bus(addr, 1'b0, 8'h00);
        @(negedge clk_in);
        check(tag, {24'h0, mem_din}, rd_exp.pop_front());
        @(posedge clk_in); #1;
    endtask

    task automatic cpu_write(input logic [17:0] addr, input logic [7:0] data);
        bus(addr, 1'b1, data);
    endtask

    task automatic drain_check(input string tag);
        int k = 0;
        logic [31:0] o;
        while (tx_obs.size() < tx_exp.size() && k < 200) begin
            @(negedge clk_in);
            k++;
        end
        repeat (4) @(negedge clk_in);
        check({tag, "_count"}, tx_obs.size(), tx_exp.size());
        while (tx_exp.size() > 0) begin
            o = (tx_obs.size() > 0) ? {24'h0, tx_obs.pop_front()} : 32'hDEAD;
            check({tag, "_byte"}, o, tx_exp.pop_front());
        end
        tx_obs.delete();
        @(posedge clk_in); #1;
    endtask

    initial begin
        int k;
        int unsigned cyc_at_halt;

        repeat (2) @(negedge clk_in);
        reset_checks("rst0");
        rst_in = 1'b1;

        // Counter snapshot: the read accepted on edge 512 sees 0x1FF.
        repeat (511) @(posedge clk_in);
        #1;
        cpu_read("cnt_b0", 18'h30004, 8'hFF);
        cpu_read("cnt_b1", 18'h30005, 8'h01);
        cpu_read("cnt_b2", 18'h30006, 8'h00);
        cpu_read("cnt_b3", 18'h30007, 8'h00);
        cpu_read("io_other", 18'h30010, 8'h00);
        cpu_read("rx_empty", 18'h30000, 8'h00);

        // RAM write then read-back.
        mem_a = 18'h00123; mem_wr = 1'b1; mem_dout = 8'h41;
        @(negedge clk_in);
        check("ram_we_hi", {31'h0, ram_we}, 32'h1);
        check("ram_addr", {15'h0, ram_addr}, 32'h00123);
        check("ram_wdata", {24'h0, ram_wdata}, 32'h41);
        @(posedge clk_in); #1;
        mem_a = 18'h0; mem_wr = 1'b0; mem_dout = 8'h00;
        @(negedge clk_in);
        check("ram_we_lo", {31'h0, ram_we}, 32'h0);
        @(posedge clk_in); #1;
        cpu_read("ram_rd", 18'h00123, 8'h41);

        // TX with zero filter.
        tx_ready = 1'b1;
        cpu_write(18'h30000, 8'h48); tx_exp.push_back(32'h48);
        cpu_write(18'h30000, 8'h00);
        cpu_write(18'h30000, 8'h69); tx_exp.push_back(32'h69);
        drain_check("tx_filter");

        // TX full back-pressure.
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cpu_write(18'h30000, 8'(i));
            tx_exp.push_back(32'(i));
        end
        @(negedge clk_in);
        check("tx_full_rdy", {31'h0, rdy_out}, 32'h0);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        @(negedge clk_in);
        check("tx_full_rdy_hold", {31'h0, rdy_out}, 32'h0);
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("tx_pop_rdy", {31'h0, rdy_out}, 32'h1);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        drain_check("tx_full");

        // RX ordering and empty read.
        rx_valid = 1'b1; rx_data = 8'h31;
        @(posedge clk_in); #1;
        rx_data = 8'h32;
        @(posedge clk_in); #1;
        rx_valid = 1'b0;
        cpu_read("rx_0", 18'h30000, 8'h31);
        cpu_read("rx_1", 18'h30000, 8'h32);
        cpu_read("rx_2", 18'h30000, 8'h00);

        // RX full: ninth byte is refused.
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'hA0 + 8'(i);
            @(posedge clk_in); #1;
        end
        rx_valid = 1'b0;
        check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        for (int i = 0; i < 8; i++) cpu_read("rx_full_data", 18'h30000, 8'hA0 + 8'(i));
        cpu_read("rx_full_empty", 18'h30000, 8'h00);

        // Stop sequence: queued bytes, then terminating 0x00, then halt.
        tx_ready = 1'b0;
        cpu_write(18'h30000, 8'h11); tx_exp.push_back(32'h11);
        cpu_write(18'h30000, 8'h22); tx_exp.push_back(32'h22);
        cpu_write(18'h30000, 8'h33); tx_exp.push_back(32'h33);
        cpu_write(18'h30004, 8'h55); tx_exp.push_back(32'h00);
        @(negedge clk_in);
        check("stop_rdy", {31'h0, rdy_out}, 32'h0);
        check("stop_not_halted", {31'h0, halted}, 32'h0);
        @(posedge clk_in); #1;
        tx_ready = 1'b1;
        k = 0;
        while (!halted && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        cyc_at_halt = cyc;
        check("halted", {31'h0, halted}, 32'h1);
        check("halt_cnt", dut.cnt_r, cyc_at_halt);
        drain_check("tx_stop");
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        check("cnt_frozen", dut.cnt_r, cyc_at_halt);
        check("halt_rdy", {31'h0, rdy_out}, 32'h0);
        check("halt_tx_valid", {31'h0, tx_valid}, 32'h0);

        // Asynchronous reset restores the idle state without a clock edge.
        #2;
        rst_in = 1'b0;
        #1;
        reset_checks("rst1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RX_DEPTH, default 8, RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have ports:
- clk_in  in  1  system clock, single clock domain
- rst_in  in  1  asynchronous active-low reset
- mem_a  in  18  CPU bus address
- mem_wr  in  1  CPU write strobe, 1 = write
- mem_dout  in  8  CPU write data
- mem_din  out  8  read data to CPU
- rdy_out  out  1  CPU ready; low freezes CPU
- ram_we  out  1  RAM write enable
- ram_addr  out  17  RAM address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid 1 cycle after address
- rx_valid  in  1  UART RX byte valid
- rx_data  in  8  UART RX byte
- rx_ready  out  1  RX FIFO can accept
- tx_valid  out  1  TX byte valid
- tx_data  out  8  TX byte
- tx_ready  in  1  UART TX accepts byte
- halted  out  1  program stopped, TX drained

Function
REQ-004 SHALL decode I/O when mem_a[17:16]==2'b11, else RAM (ram_addr = mem_a[16:0]).
REQ-005 SHALL accept a bus access only in a cycle where rdy_out==1; ignore bus otherwise.
REQ-006 SHALL drive ram_we = mem_wr & ~io & rdy_out combinationally; ram_wdata = mem_dout.
REQ-007 SHALL return read data on mem_din in the cycle after the read (2-cycle read), via a registered source select: RAM, RX byte, counter byte, or 0x00.
REQ-008 SHALL make a read of 0x30000 pop the RX FIFO and return its head; RX empty returns 0x00, no pop.
REQ-009 SHALL make a write of 0x30000 push mem_dout into the TX FIFO; data 0x00 is discarded.
REQ-010 SHALL keep a 32-bit cycle counter, +1 per cycle while state != HALTED, wrapping 0xFFFFFFFF->0.
REQ-011 SHALL, on a read of 0x30004, snapshot the counter and return byte 0; reads of 0x30005/6/7 return snapshot bytes 1/2/3 (little-endian), counter not re-sampled.
REQ-012 SHALL return 0x00 for reads of other I/O addresses; other I/O writes are ignored.
REQ-013 SHALL implement FSM RUN -> STOP -> HALTED: write of 0x30004 in RUN pushes 0x00 into TX (REQ-009 filter bypassed) and enters STOP; STOP -> HALTED when TX FIFO empty and no byte in flight; HALTED is terminal until reset.
REQ-014 SHALL drive rdy_out = (state==RUN) & ~tx_full; a 0x30004 write with TX full waits for rdy_out.
REQ-015 SHALL drive tx_valid = ~tx_empty, tx_data = TX head; pop on tx_valid & tx_ready.
REQ-016 SHALL drive rx_ready = ~rx_full; push on rx_valid & rx_ready.
REQ-017 SHALL support simultaneous push and pop on either FIFO in one cycle, full or empty: count unchanged when both occur, except pop on empty/push on full are blocked.
REQ-018 SHALL drive halted = (state==HALTED).

Reset
REQ-019 SHALL on rst_in low, asynchronously: state RUN, FIFOs empty, counter 0, snapshot 0, read select RAM, mem_din 0x00, tx_valid 0, rx_ready 1, rdy_out 1, halted 0; reset mid-transfer drops FIFO contents.

Structure
REQ-020 SHALL place I/O address constants (0x30000, 0x30004), FSM state encoding and read-select encoding in the shared defines package.
REQ-021 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH, DEPTH), twice for TX and RX.

Verification
REQ-022 SHALL cover: CPU writes 0x41 to RAM addr 0x00123, reads it back -> ram_we pulse, mem_din=0x41 one cycle after read.
REQ-023 SHALL cover: writes 0x48, 0x00, 0x69 to 0x30000, tx_ready=1 -> tx_data sequence 0x48, 0x69 only.
REQ-024 SHALL cover: tx_ready=0, 8 writes to 0x30000 -> rdy_out low after 8th; tx_ready=1 for one cycle -> rdy_out high next cycle.
REQ-025 SHALL cover: RX bytes 0x31, 0x32 pushed, three reads of 0x30000 -> 0x31, 0x32, 0x00.
REQ-026 SHALL cover: counter at 0x000001FF, reads 0x30004..0x30007 -> 0xFF, 0x01, 0x00, 0x00.
REQ-027 SHALL cover: 3 bytes queued, write 0x30004 -> rdy_out low, TX emits 3 bytes then 0x00, halted=1, counter frozen; rst_in low -> all REQ-019 values.
